ahb_fifo_io_slave: RTL and testbench



---
 rtl/ahb_fifo_io_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_ahb_fifo_io_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_fifo_io_slave.sv
// rtl/ahb_fifo_io_slave.sv - AHB-Lite slave bridging 32-bit bus words to the crypto core's 128-bit FIFOs
module ahb_fifo_io_slave (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         HSELx,
  input  logic [1:0]   HTRANS,
  input  logic [31:0]  HADDR,
  input  logic         HWRITE,
  input  logic [31:0]  HWDATA,
  input  logic [2:0]   HBURST,
  input  logic [2:0]   HSIZE,
  input  logic [3:0]   HPROT,
  input  logic [7:0]   status,
  input  logic [127:0] data_in,
  input  logic         tx_enq,
  input  logic         rcv_deq,
  input  logic         fix_error,
  output logic [31:0]  HRDATA,
  output logic         HREADY,
  output logic [1:0]   HRESP,
  output logic         is_encrypt_pulse,
  output logic         is_decrypt_pulse,
  output logic         key_in,
  output logic [127:0] rcv_fifo_out,
  output logic         tx_fifo_full,
  output logic         tx_fifo_empty,
  output logic         rcv_fifo_full,
  output logic         rcv_fifo_empty,
  output logic         framing_error
);

  typedef enum logic [1:0] {RESP_OKAY, RESP_ERR1, RESP_ERR2} resp_state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  resp_state_t resp_state;

  // Burst/size/protection carry no meaning here; every access is a 32-bit word.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HSIZE, HPROT};

  // Address decode
  logic [7:0] addr_lo;
  logic       hi_zero, in_tx;
  logic       dec_status, dec_enc, dec_dec, dec_key, dec_data, dec_tx, dec_legal;
  logic       xfer, nonseq, burst_end;

  assign addr_lo    = HADDR[7:0];
  assign hi_zero    = (HADDR[31:8] == 24'd0);
  assign in_tx      = (addr_lo >= 8'h80) && (addr_lo <= 8'hDF);
  assign dec_status = hi_zero & (addr_lo == 8'h00) & ~HWRITE;
  assign dec_enc    = hi_zero & (addr_lo == 8'h04) &  HWRITE;
  assign dec_dec    = hi_zero & (addr_lo == 8'h08) &  HWRITE;
  assign dec_key    = hi_zero & (addr_lo[7:4] == 4'h1) & HWRITE;
  assign dec_data   = hi_zero & (addr_lo[7:6] == 2'b01) & HWRITE;
  assign dec_tx     = hi_zero & in_tx & ~HWRITE;
  assign dec_legal  = dec_status | dec_enc | dec_dec | dec_key | dec_data | dec_tx;

  assign xfer      = HSELx & HTRANS[1] & HREADY;
  assign nonseq    = (HTRANS == TRANS_NONSEQ);
  // A write burst is over once the bus starts something new or goes quiet.
  assign burst_end = HREADY & (~HSELx | (HTRANS == TRANS_IDLE) | nonseq);

  // Receive FIFO state
  logic [127:0] rx_mem [0:3];
  logic [3:0]   rx_tag;
  logic [1:0]   rx_wr_ptr, rx_rd_ptr;
  logic [2:0]   rx_count;

  // Transmit FIFO state
  logic [127:0] tx_mem [0:7];
  logic [2:0]   tx_wr_ptr, tx_rd_ptr;
  logic [3:0]   tx_count;

  assign rcv_fifo_full  = (rx_count == 3'd4);
  assign rcv_fifo_empty = (rx_count == 3'd0);
  assign tx_fifo_full   = (tx_count == 4'd8);
  assign tx_fifo_empty  = (tx_count == 4'd0);
  assign rcv_fifo_out   = rcv_fifo_empty ? 128'd0 : rx_mem[rx_rd_ptr];
  assign key_in         = ~rcv_fifo_empty & rx_tag[rx_rd_ptr];

  // Write packing / read streaming state
  logic [1:0]  wcnt, wcnt_inc, cnt_after;
  logic [1:0]  rcnt, rd_idx;
  logic [95:0] pack_buf;
  logic        dp_wr, dp_key;
  logic        rx_push_req, rx_push, rx_pop, rx_overflow, partial_drop;
  logic        tx_push, tx_pop;
  logic [127:0] tx_head;
  logic [31:0] tx_word;

  assign wcnt_inc     = wcnt + 2'd1;
  assign cnt_after    = dp_wr ? wcnt_inc : wcnt;
  assign partial_drop = burst_end & (cnt_after != 2'd0);
  assign rx_push_req  = dp_wr & (wcnt == 2'd3);
  assign rx_push      = rx_push_req & ~rcv_fifo_full;
  assign rx_overflow  = rx_push_req & rcv_fifo_full;
  assign rx_pop       = rcv_deq & ~rcv_fifo_empty;

  assign rd_idx  = nonseq ? 2'd0 : rcnt;
  assign tx_push = tx_enq & ~tx_fifo_full;
  assign tx_pop  = xfer & dec_tx & (rd_idx == 2'd3) & ~tx_fifo_empty;
  assign tx_head = tx_mem[tx_rd_ptr];

  // Select the 32-bit slice of the TX head for the current read beat, MSW first
  always_comb begin
    tx_word = 32'd0;
    case (rd_idx)
      2'd0: tx_word = tx_head[127:96];
      2'd1: tx_word = tx_head[95:64];
      2'd2: tx_word = tx_head[63:32];
      default: tx_word = tx_head[31:0];
    endcase
  end

  // Response FSM: two-cycle ERROR for illegal accesses, otherwise zero-wait OKAY
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_state <= RESP_OKAY;
      HREADY     <= 1'b1;
      HRESP      <= 2'd0;
    end else begin
      case (resp_state)
        RESP_ERR1: begin
          resp_state <= RESP_ERR2;
          HREADY     <= 1'b1;
          HRESP      <= 2'd1;
        end
        default: begin
          if (xfer && !dec_legal) begin
            resp_state <= RESP_ERR1;
            HREADY     <= 1'b0;
            HRESP      <= 2'd1;
          end else begin
            resp_state <= RESP_OKAY;
            HREADY     <= 1'b1;
            HRESP      <= 2'd0;
          end
        end
      endcase
    end
  end

  // Address-phase actions: command strobes, read data, read counter, pending write flags
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      is_encrypt_pulse <= 1'b0;
      is_decrypt_pulse <= 1'b0;
      HRDATA           <= 32'd0;
      rcnt             <= 2'd0;
      dp_wr            <= 1'b0;
      dp_key           <= 1'b0;
    end else begin
      is_encrypt_pulse <= xfer & dec_enc;
      is_decrypt_pulse <= xfer & dec_dec;
      dp_wr            <= xfer & (dec_key | dec_data);
      dp_key           <= dec_key;
      if (xfer) begin
        rcnt <= dec_tx ? (rd_idx + 2'd1) : 2'd0;
      end
      if (xfer && dec_status) begin
        HRDATA <= {24'd0, status};
      end else if (xfer && dec_tx) begin
        HRDATA <= tx_fifo_empty ? 32'd0 : tx_word;
      end
    end
  end

  // Data-phase packing of key/data words and the sticky framing error
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wcnt          <= 2'd0;
      pack_buf      <= 96'd0;
      framing_error <= 1'b0;
    end else begin
      if (dp_wr) begin
        case (wcnt)
          2'd0: pack_buf[95:64] <= HWDATA;
          2'd1: pack_buf[63:32] <= HWDATA;
          2'd2: pack_buf[31:0]  <= HWDATA;
          default: ;
        endcase
      end
      if (burst_end) begin
        wcnt <= 2'd0;
      end else if (dp_wr) begin
        wcnt <= wcnt_inc;
      end
      framing_error <= (framing_error & ~fix_error) | partial_drop | rx_overflow;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_wr_ptr <= 2'd0;
      rx_rd_ptr <= 2'd0;
      rx_count  <= 3'd0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 2'd1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 2'd1;
      rx_count <= rx_count + {2'b00, rx_push} - {2'b00, rx_pop};
    end
  end

  // RX FIFO storage; the 4th word goes straight from HWDATA into the entry
  always_ff @(posedge HCLK) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= {pack_buf, HWDATA};
      rx_tag[rx_wr_ptr] <= dp_key;
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_wr_ptr <= 3'd0;
      tx_rd_ptr <= 3'd0;
      tx_count  <= 4'd0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 3'd1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 3'd1;
      tx_count <= tx_count + {3'b000, tx_push} - {3'b000, tx_pop};
    end
  end

  // TX FIFO storage
  always_ff @(posedge HCLK) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_ahb_fifo_io_slave.sv
// tb/tb_ahb_fifo_io_slave.sv - directed self-checking bench for ahb_fifo_io_slave
module tb_ahb_fifo_io_slave;

  logic         tb_HCLK = 1'b0;
  logic         HRESETn;
  logic         HSELx;
  logic [1:0]   HTRANS;
  logic [31:0]  HADDR;
  logic         HWRITE;
  logic [31:0]  HWDATA;
  logic [2:0]   HBURST;
  logic [2:0]   HSIZE;
  logic [3:0]   HPROT;
  logic [7:0]   status;
  logic [127:0] data_in;
  logic         tx_enq, rcv_deq, fix_error;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic         is_encrypt_pulse, is_decrypt_pulse, key_in;
  logic [127:0] rcv_fifo_out;
  logic         tx_fifo_full, tx_fifo_empty, rcv_fifo_full, rcv_fifo_empty;
  logic         framing_error;

  int errors = 0;
  int checks = 0;

  logic [31:0] s_addr [0:31];
  logic [1:0]  s_trans [0:31];
  logic [31:0] s_data [0:31];
  logic        s_deq [0:31];
  logic [31:0] rd_buf [0:63];

  always #5 tb_HCLK = ~tb_HCLK;

  ahb_fifo_io_slave dut (
    .HCLK(tb_HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HBURST(HBURST), .HSIZE(HSIZE), .HPROT(HPROT),
    .status(status), .data_in(data_in), .tx_enq(tx_enq), .rcv_deq(rcv_deq),
    .fix_error(fix_error), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .is_encrypt_pulse(is_encrypt_pulse), .is_decrypt_pulse(is_decrypt_pulse),
    .key_in(key_in), .rcv_fifo_out(rcv_fifo_out), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_empty(tx_fifo_empty), .rcv_fifo_full(rcv_fifo_full),
    .rcv_fifo_empty(rcv_fifo_empty), .framing_error(framing_error)
  );

  function automatic logic [31:0] tx_word(input int k, input int j);
    return 32'hB000_0000 + 32'(k * 256 + j);
  endfunction

  function automatic logic [127:0] tx_block(input int k);
    return {tx_word(k, 0), tx_word(k, 1), tx_word(k, 2), tx_word(k, 3)};
  endfunction

  task automatic set_block(input int idx, input logic [31:0] base, input logic ns,
                           input logic [127:0] val);
    for (int j = 0; j < 4; j++) begin
      s_addr[idx + j]  = base + 32'(4 * j);
      s_trans[idx + j] = (j == 0 && ns) ? 2'b10 : 2'b11;
      s_data[idx + j]  = val[127 - 32 * j -: 32];
      s_deq[idx + j]   = 1'b0;
    end
  endtask

  task automatic run_write(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge tb_HCLK);
      if (i < n) begin
        HSELx = 1'b1; HWRITE = 1'b1; HADDR = s_addr[i]; HTRANS = s_trans[i];
        rcv_deq = s_deq[i];
      end else begin
        HSELx = 1'b0; HTRANS = 2'b00; rcv_deq = 1'b0;
      end
      HWDATA = (i > 0) ? s_data[i - 1] : 32'd0;
    end
  endtask

  task automatic run_read(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge tb_HCLK);
      if (i > 0) rd_buf[i - 1] = HRDATA;
      if (i < n) begin
        HSELx = 1'b1; HWRITE = 1'b0;
        HADDR = 32'h80 + 32'(4 * (i % 24));
        HTRANS = (i % 24 == 0) ? 2'b10 : 2'b11;
      end else begin
        HSELx = 1'b0; HTRANS = 2'b00;
      end
    end
  endtask

  task automatic deq_one();
    @(negedge tb_HCLK); rcv_deq = 1'b1;
    @(negedge tb_HCLK); rcv_deq = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(negedge tb_HCLK);
    HRESETn = 1'b1;
    @(negedge tb_HCLK);
    checks++; if (HRDATA !== 32'd0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b want 1", HREADY); end
    checks++; if (HRESP !== 2'd0) begin errors++; $display("FAIL reset_hresp: got %0d want 0", HRESP); end
    checks++; if (is_encrypt_pulse !== 1'b0) begin errors++; $display("FAIL reset_enc: got %b want 0", is_encrypt_pulse); end
    checks++; if (is_decrypt_pulse !== 1'b0) begin errors++; $display("FAIL reset_dec: got %b want 0", is_decrypt_pulse); end
    checks++; if (key_in !== 1'b0) begin errors++; $display("FAIL reset_key_in: got %b want 0", key_in); end
    checks++; if (rcv_fifo_out !== 128'd0) begin errors++; $display("FAIL reset_rx_out: got %h want 0", rcv_fifo_out); end
    checks++; if (rcv_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b want 1", rcv_fifo_empty); end
    checks++; if (rcv_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_rx_full: got %b want 0", rcv_fifo_full); end
    checks++; if (tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty: got %b want 1", tx_fifo_empty); end
    checks++; if (tx_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b want 0", tx_fifo_full); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing: got %b want 0", framing_error); end
  endtask

  task automatic test_key_block();
    logic [127:0] key;
    key = "ZXCVBNMASDFGHJKL";
    set_block(0, 32'h10, 1'b1, key);
    run_write(4);
    @(negedge tb_HCLK);
    checks++; if (rcv_fifo_out !== key) begin errors++; $display("FAIL key_head: got %h want %h", rcv_fifo_out, key); end
    checks++; if (key_in !== 1'b1) begin errors++; $display("FAIL key_tag: got %b want 1", key_in); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL key_framing: got %b want 0", framing_error); end
    deq_one();
    checks++; if (rcv_fifo_empty !== 1'b1) begin errors++; $display("FAIL key_deq_empty: got %b want 1", rcv_fifo_empty); end
    checks++; if (rcv_fifo_out !== 128'd0) begin errors++; $display("FAIL key_deq_out: got %h want 0", rcv_fifo_out); end
  endtask

  task automatic test_key_then_data();
    logic [127:0] key, dat;
    key = "ZXCVBNMASDFGHJKL";
    dat = "1234567890123456";
    set_block(0, 32'h10, 1'b1, key);
    set_block(4, 32'h40, 1'b1, dat);
    run_write(8);
    @(negedge tb_HCLK);
    checks++; if (rcv_fifo_out !== key) begin errors++; $display("FAIL kd_head0: got %h want %h", rcv_fifo_out, key); end
    checks++; if (key_in !== 1'b1) begin errors++; $display("FAIL kd_tag0: got %b want 1", key_in); end
    deq_one();
    checks++; if (rcv_fifo_out !== dat) begin errors++; $display("FAIL kd_head1: got %h want %h", rcv_fifo_out, dat); end
    checks++; if (key_in !== 1'b0) begin errors++; $display("FAIL kd_tag1: got %b want 0", key_in); end
    deq_one();
    checks++; if (rcv_fifo_empty !== 1'b1) begin errors++; $display("FAIL kd_empty: got %b want 1", rcv_fifo_empty); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [0:3];
    for (int b = 0; b < 4; b++) begin
      blk[b] = {32'hD000_0000 + 32'(b * 16), 32'hD000_0001 + 32'(b * 16),
                32'hD000_0002 + 32'(b * 16), 32'hD000_0003 + 32'(b * 16)};
      set_block(4 * b, 32'h40 + 32'(16 * b), (b == 0), blk[b]);
    end
    s_deq[6] = 1'b1;
    run_write(16);
    @(negedge tb_HCLK);
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL b2b_framing: got %b want 0", framing_error); end
    checks++; if (rcv_fifo_full !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", rcv_fifo_full); end
    for (int b = 1; b < 4; b++) begin
      checks++;
      if (rcv_fifo_out !== blk[b]) begin errors++; $display("FAIL b2b_head%0d: got %h want %h", b, rcv_fifo_out, blk[b]); end
      deq_one();
    end
    checks++; if (rcv_fifo_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", rcv_fifo_empty); end
  endtask

  task automatic test_tx_stream();
    for (int k = 0; k < 6; k++) begin
      @(negedge tb_HCLK); data_in = tx_block(k); tx_enq = 1'b1;
    end
    @(negedge tb_HCLK); tx_enq = 1'b0;
    checks++; if (tx_fifo_empty !== 1'b0) begin errors++; $display("FAIL tx6_empty: got %b want 0", tx_fifo_empty); end
    checks++; if (tx_fifo_full !== 1'b0) begin errors++; $display("FAIL tx6_full: got %b want 0", tx_fifo_full); end
    run_read(24);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (rd_buf[i] !== tx_word(i / 4, i % 4)) begin
        errors++; $display("FAIL tx6_word%0d: got %h want %h", i, rd_buf[i], tx_word(i / 4, i % 4));
      end
    end
    checks++; if (tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL tx6_drained: got %b want 1", tx_fifo_empty); end
  endtask

  task automatic test_tx_full();
    for (int k = 0; k < 9; k++) begin
      @(negedge tb_HCLK); data_in = tx_block(k + 16); tx_enq = 1'b1;
    end
    @(negedge tb_HCLK); tx_enq = 1'b0;
    checks++; if (tx_fifo_full !== 1'b1) begin errors++; $display("FAIL txf_full: got %b want 1", tx_fifo_full); end
    run_read(32);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rd_buf[i] !== tx_word(i / 4 + 16, i % 4)) begin
        errors++; $display("FAIL txf_word%0d: got %h want %h", i, rd_buf[i], tx_word(i / 4 + 16, i % 4));
      end
    end
    checks++; if (tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL txf_drained: got %b want 1", tx_fifo_empty); end
    run_read(1);
    checks++; if (rd_buf[0] !== 32'd0) begin errors++; $display("FAIL txf_empty_read: got %h want 0", rd_buf[0]); end
    checks++; if (HRESP !== 2'd0) begin errors++; $display("FAIL txf_empty_resp: got %0d want 0", HRESP); end
  endtask

  task automatic test_error();
    @(negedge tb_HCLK); HSELx = 1'b1; HTRANS = 2'b10; HADDR = 32'h128; HWRITE = 1'b1;
    @(negedge tb_HCLK);
    checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL err_c1_hready: got %b want 0", HREADY); end
    checks++; if (HRESP !== 2'd1) begin errors++; $display("FAIL err_c1_hresp: got %0d want 1", HRESP); end
    HADDR = 32'h04; HTRANS = 2'b10; HWDATA = 32'hDEAD_BEEF;
    @(negedge tb_HCLK); HSELx = 1'b0; HTRANS = 2'b00;
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL err_c2_hready: got %b want 1", HREADY); end
    checks++; if (HRESP !== 2'd1) begin errors++; $display("FAIL err_c2_hresp: got %0d want 1", HRESP); end
    checks++; if (is_encrypt_pulse !== 1'b0) begin errors++; $display("FAIL err_c2_ignored: got %b want 0", is_encrypt_pulse); end
    @(negedge tb_HCLK);
    checks++; if (HRESP !== 2'd0) begin errors++; $display("FAIL err_okay_hresp: got %0d want 0", HRESP); end
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL err_okay_hready: got %b want 1", HREADY); end
    checks++; if (is_encrypt_pulse !== 1'b0) begin errors++; $display("FAIL err_okay_ignored: got %b want 0", is_encrypt_pulse); end
    checks++; if (rcv_fifo_empty !== 1'b1) begin errors++; $display("FAIL err_no_push: got %b want 1", rcv_fifo_empty); end
  endtask

  task automatic test_commands();
    @(negedge tb_HCLK); HSELx = 1'b1; HTRANS = 2'b10; HADDR = 32'h08; HWRITE = 1'b1;
    @(negedge tb_HCLK); HSELx = 1'b0; HTRANS = 2'b00;
    checks++; if (is_decrypt_pulse !== 1'b1) begin errors++; $display("FAIL dec_pulse_hi: got %b want 1", is_decrypt_pulse); end
    checks++; if (is_encrypt_pulse !== 1'b0) begin errors++; $display("FAIL dec_enc_lo: got %b want 0", is_encrypt_pulse); end
    @(negedge tb_HCLK);
    checks++; if (is_decrypt_pulse !== 1'b0) begin errors++; $display("FAIL dec_pulse_lo: got %b want 0", is_decrypt_pulse); end
    HSELx = 1'b1; HTRANS = 2'b10; HADDR = 32'h04; HWRITE = 1'b1;
    @(negedge tb_HCLK); HSELx = 1'b0; HTRANS = 2'b00;
    checks++; if (is_encrypt_pulse !== 1'b1) begin errors++; $display("FAIL enc_pulse_hi: got %b want 1", is_encrypt_pulse); end
    @(negedge tb_HCLK);
    checks++; if (is_encrypt_pulse !== 1'b0) begin errors++; $display("FAIL enc_pulse_lo: got %b want 0", is_encrypt_pulse); end
    status = 8'h41;
    HSELx = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b0;
    @(negedge tb_HCLK); HSELx = 1'b0; HTRANS = 2'b00;
    checks++; if (HRDATA !== 32'h0000_0041) begin errors++; $display("FAIL status_read: got %h want 00000041", HRDATA); end
    checks++; if (HRESP !== 2'd0) begin errors++; $display("FAIL status_resp: got %0d want 0", HRESP); end
  endtask

  task automatic test_framing();
    logic [127:0] blk [0:4];
    set_block(0, 32'h40, 1'b1, 128'h1111_1111_2222_2222_3333_3333_4444_4444);
    run_write(2);
    @(negedge tb_HCLK);
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL frm_partial: got %b want 1", framing_error); end
    checks++; if (rcv_fifo_empty !== 1'b1) begin errors++; $display("FAIL frm_no_push: got %b want 1", rcv_fifo_empty); end
    @(negedge tb_HCLK); fix_error = 1'b1;
    @(negedge tb_HCLK); fix_error = 1'b0;
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL frm_fix: got %b want 0", framing_error); end
    for (int b = 0; b < 5; b++) begin
      blk[b] = {4{32'hE000_0000 + 32'(b)}};
      set_block(4 * b, 32'h10, 1'b1, blk[b]);
    end
    run_write(20);
    @(negedge tb_HCLK);
    checks++; if (rcv_fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", rcv_fifo_full); end
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL ovf_framing: got %b want 1", framing_error); end
    checks++; if (rcv_fifo_out !== blk[0]) begin errors++; $display("FAIL ovf_head: got %h want %h", rcv_fifo_out, blk[0]); end
    HSELx = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1;
    @(negedge tb_HCLK); HTRANS = 2'b11; HADDR = 32'h44; HWDATA = 32'h5555_5555;
    #1 HRESETn = 1'b0;
    #1;
    checks++; if (rcv_fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b want 1", rcv_fifo_empty); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL rst_mid_framing: got %b want 0", framing_error); end
    checks++; if (rcv_fifo_full !== 1'b0) begin errors++; $display("FAIL rst_mid_full: got %b want 0", rcv_fifo_full); end
    @(negedge tb_HCLK); HSELx = 1'b0; HTRANS = 2'b00; HRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; HSELx = 1'b0; HTRANS = 2'b00; HADDR = 32'd0; HWRITE = 1'b0;
    HWDATA = 32'd0; HBURST = 3'd1; HSIZE = 3'd2; HPROT = 4'd0; status = 8'd0;
    data_in = 128'd0; tx_enq = 1'b0; rcv_deq = 1'b0; fix_error = 1'b0;
    test_reset();
    test_key_block();
    test_key_then_data();
    test_back_to_back();
    test_tx_stream();
    test_tx_full();
    test_error();
    test_commands();
    test_framing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
